rca_multicycle_nb: RTL and testbench



---
 rtl/rca_multicycle_nb.sv | 138 +++++++++++++
 tb/tb_rca_multicycle_nb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_multicycle_nb.sv
// Multi-cycle ripple-carry adder/subtractor. Adds CHUNK bits per clock, LSB chunk first,
// and keeps the inter-chunk carry in a register. Valid/ready handshake on both sides.
module rca_multicycle_nb #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             Ofl,
  output logic             Zero
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_upd;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             c_out_reg, ofl_reg, zero_reg;

  logic [CHUNK-1:0] a_cur, b_cur;
  logic [CHUNK:0]   sum_ext;
  logic             msb_cin;
  logic             accept, last_chunk;

  assign accept     = (state_reg == IDLE) && in_valid;
  assign last_chunk = (cnt_reg == LAST_CHUNK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Select the operand chunk addressed by the counter
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_cur = a_reg[i*CHUNK +: CHUNK];
        b_cur = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  assign sum_ext = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
  // Carry into the chunk's top bit, recovered from that bit's sum and operands
  assign msb_cin = sum_ext[CHUNK-1] ^ a_cur[CHUNK-1] ^ b_cur[CHUNK-1];

  // S with the current chunk replaced; lets Zero see the completed result on the last edge
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      assign s_upd[gi*CHUNK +: CHUNK] = (cnt_reg == CW'(gi)) ? sum_ext[CHUNK-1:0]
                                                              : s_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      ofl_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= Op ? ~B : B;
      carry_reg <= Op ? 1'b1 : C_in;
      cnt_reg   <= '0;
    end else if (state_reg == BUSY) begin
      s_reg     <= s_upd;
      carry_reg <= sum_ext[CHUNK];
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_chunk) begin
        c_out_reg <= sum_ext[CHUNK];
        ofl_reg   <= msb_cin ^ sum_ext[CHUNK];
        zero_reg  <= (s_upd == '0);
      end
    end
  end

  assign S     = s_reg;
  assign C_out = c_out_reg;
  assign Ofl   = ofl_reg;
  assign Zero  = zero_reg;

endmodule

// File: tb/tb_rca_multicycle_nb.sv
// Bench for rca_multicycle_nb: directed, backpressure, async reset and random checks on a
// 16/4 instance, plus a latency/result sweep over 16/1, 16/16 and 32/8 instances.
module tb_rca_multicycle_nb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main 16/4 instance
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] a = '0, b = '0;
  logic        c_in = 1'b0, op = 1'b0;
  logic [15:0] s;
  logic        c_out, ofl, zero;

  rca_multicycle_nb #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .C_in(c_in), .Op(op), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .C_out(c_out), .Ofl(ofl), .Zero(zero));

  // Sweep instances share operands; each consumes its result immediately
  logic        sw_valid = 1'b0, sw_out_ready = 1'b1;
  logic [31:0] sw_a = '0, sw_b = '0;
  logic        sw_op = 1'b0, sw_cin = 1'b0;
  logic        c1_ir, c1_ov, c1_co, c1_of, c1_z;
  logic        c16_ir, c16_ov, c16_co, c16_of, c16_z;
  logic        w32_ir, w32_ov, w32_co, w32_of, w32_z;
  logic [15:0] c1_s, c16_s;
  logic [31:0] w32_s;

  rca_multicycle_nb #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(c1_ir),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .C_in(sw_cin), .Op(sw_op), .out_valid(c1_ov),
    .out_ready(sw_out_ready), .S(c1_s), .C_out(c1_co), .Ofl(c1_of), .Zero(c1_z));

  rca_multicycle_nb #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(c16_ir),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .C_in(sw_cin), .Op(sw_op), .out_valid(c16_ov),
    .out_ready(sw_out_ready), .S(c16_s), .C_out(c16_co), .Ofl(c16_of), .Zero(c16_z));

  rca_multicycle_nb #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(w32_ir),
    .A(sw_a), .B(sw_b), .C_in(sw_cin), .Op(sw_op), .out_valid(w32_ov),
    .out_ready(sw_out_ready), .S(w32_s), .C_out(w32_co), .Ofl(w32_of), .Zero(w32_z));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: integer arithmetic. Returns {S[31:0], C_out, Ofl, Zero}
  function automatic logic [34:0] ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                             input logic opv, input logic cinv);
    longint modv, half, ua, ub, sa, sb, ures, sres;
    logic co, of, z;
    logic [31:0] s32;
    modv = longint'(1) << w;
    half = modv >> 1;
    ua = longint'(av) & (modv - 1);
    ub = longint'(bv) & (modv - 1);
    sa = (ua >= half) ? ua - modv : ua;
    sb = (ub >= half) ? ub - modv : ub;
    if (!opv) begin
      ures = ua + ub + longint'(cinv);
      sres = sa + sb + longint'(cinv);
      co   = (ures >= modv);
    end else begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
      if (ures < 0) ures = ures + modv;
    end
    ures = ures % modv;
    of  = (sres >= half) || (sres < -half);
    z   = (ures == 0);
    s32 = ures[31:0];
    return {s32, co, of, z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic busy_ready_seen;
  logic timed_out;
  int   lat;

  // Accept one operation, scramble inputs afterwards, count edges until out_valid
  task automatic issue_and_wait(input logic [15:0] av, input logic [15:0] bv,
                                input logic opv, input logic cinv);
    int guard;
    guard = 0;
    timed_out = 1'b0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    a = av; b = bv; op = opv; c_in = cinv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); c_in = 1'($urandom);
    lat = 0;
    busy_ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready_seen = 1'b1;
      tick();
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_handshake: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({s, c_out, ofl, zero} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got S=%h C/O/Z=%b want S=0000 C/O/Z=000", s, {c_out, ofl, zero});
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        of;
    logic        z;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [7];
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      issue_and_wait(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
      n_checks++;
      if (timed_out || lat !== 4) begin
        n_fail++;
        $display("FAIL directed%0d_latency: got %0d edges want 4", i, lat);
      end
      n_checks++;
      if (busy_ready_seen !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_in_ready_busy: got in_ready=1 while busy want 0", i);
      end
      n_checks++;
      if ({s, c_out, ofl, zero} !== {vecs[i].s, vecs[i].co, vecs[i].of, vecs[i].z}) begin
        n_fail++;
        $display("FAIL directed%0d_result: got S=%h C/O/Z=%b want S=%h C/O/Z=%b", i, s,
                 {c_out, ofl, zero}, vecs[i].s, {vecs[i].co, vecs[i].of, vecs[i].z});
      end
      $display("directed%0d: A=%h B=%h Op=%b Cin=%b -> S=%h C=%b O=%b Z=%b lat=%0d", i,
               vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, s, c_out, ofl, zero, lat);
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] m;
    logic [18:0] exp;
    m   = ref_model(16, 32'h0000A5A5, 32'h00005A5A, 1'b0, 1'b1);
    exp = {m[18:3], m[2:0]};
    issue_and_wait(16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL hold%0d_handshake: got out_valid/in_ready=%b want 10", i, {out_valid, in_ready});
      end
      n_checks++;
      if ({s, c_out, ofl, zero} !== exp) begin
        n_fail++;
        $display("FAIL hold%0d_result: got %h want %h", i, {s, c_out, ofl, zero}, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_cycle_in_ready: got %b want 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_handshake: got out_valid/in_ready=%b want 01", {out_valid, in_ready});
    end
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL no_spurious_accept: got out_valid/in_ready=%b want 01", {out_valid, in_ready});
    end
    $display("backpressure: S=%h held 5 cycles, released", exp[18:3]);
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    a = 16'hFFFF; b = 16'h0001; op = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL async_reset_handshake: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({s, c_out, ofl, zero} !== 19'h0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got S=%h C/O/Z=%b want 0", s, {c_out, ofl, zero});
    end
    #2 rst_n = 1'b1;
    tick();
    issue_and_wait(16'h0001, 16'h0001, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || lat !== 4) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d want 4", lat);
    end
    n_checks++;
    if ({s, c_out, ofl, zero} !== {16'h0002, 3'b000}) begin
      n_fail++;
      $display("FAIL post_reset_result: got S=%h C/O/Z=%b want S=0002 C/O/Z=000", s, {c_out, ofl, zero});
    end
    $display("async_reset: aborted FFFF+0001, then 0001+0001 -> S=%h", s);
    consume();
  endtask

  task automatic test_random();
    logic [15:0] av, bv;
    logic        opv, cinv;
    logic [34:0] m;
    for (int i = 0; i < 24; i++) begin
      av = 16'($urandom); bv = 16'($urandom);
      opv = 1'($urandom); cinv = 1'($urandom);
      m = ref_model(16, {16'h0, av}, {16'h0, bv}, opv, cinv);
      issue_and_wait(av, bv, opv, cinv);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      n_checks++;
      if (timed_out || lat !== 4 || {s, c_out, ofl, zero} !== {m[18:3], m[2:0]}) begin
        n_fail++;
        $display("FAIL random%0d: got S=%h C/O/Z=%b lat=%0d want S=%h C/O/Z=%b lat=4", i, s,
                 {c_out, ofl, zero}, lat, m[18:3], m[2:0]);
      end
      $display("random%0d: A=%h B=%h Op=%b Cin=%b -> S=%h C=%b O=%b Z=%b", i, av, bv, opv, cinv,
               s, c_out, ofl, zero);
      consume();
    end
  endtask

  task automatic test_sweep();
    int lat_c1, lat_c16, lat_w32, guard;
    logic [18:0] got_c1, got_c16;
    logic [34:0] got_w32, m16, m32;
    for (int i = 0; i < 12; i++) begin
      guard = 0;
      while (!(c1_ir && c16_ir && w32_ir) && guard < 50) begin
        tick();
        guard++;
      end
      if (i == 0) begin
        sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_op = 1'b0; sw_cin = 1'b0;
      end else if (i == 1) begin
        sw_a = 32'h8000_8000; sw_b = 32'h0000_0001; sw_op = 1'b1; sw_cin = 1'b0;
      end else begin
        sw_a = $urandom; sw_b = $urandom; sw_op = 1'($urandom); sw_cin = 1'($urandom);
      end
      m16 = ref_model(16, sw_a, sw_b, sw_op, sw_cin);
      m32 = ref_model(32, sw_a, sw_b, sw_op, sw_cin);
      sw_valid = 1'b1;
      tick();
      sw_valid = 1'b0;
      lat_c1 = -1; lat_c16 = -1; lat_w32 = -1;
      got_c1 = '0; got_c16 = '0; got_w32 = '0;
      for (int k = 1; k <= 40 && (lat_c1 < 0 || lat_c16 < 0 || lat_w32 < 0); k++) begin
        tick();
        if (c1_ov && lat_c1 < 0) begin
          lat_c1 = k; got_c1 = {c1_s, c1_co, c1_of, c1_z};
        end
        if (c16_ov && lat_c16 < 0) begin
          lat_c16 = k; got_c16 = {c16_s, c16_co, c16_of, c16_z};
        end
        if (w32_ov && lat_w32 < 0) begin
          lat_w32 = k; got_w32 = {w32_s, w32_co, w32_of, w32_z};
        end
      end
      n_checks++;
      if (lat_c1 != 16 || got_c1 !== {m16[18:3], m16[2:0]}) begin
        n_fail++;
        $display("FAIL sweep%0d_w16c1: got %h lat=%0d want %h lat=16", i, got_c1, lat_c1,
                 {m16[18:3], m16[2:0]});
      end
      n_checks++;
      if (lat_c16 != 1 || got_c16 !== {m16[18:3], m16[2:0]}) begin
        n_fail++;
        $display("FAIL sweep%0d_w16c16: got %h lat=%0d want %h lat=1", i, got_c16, lat_c16,
                 {m16[18:3], m16[2:0]});
      end
      n_checks++;
      if (lat_w32 != 4 || got_w32 !== m32) begin
        n_fail++;
        $display("FAIL sweep%0d_w32c8: got %h lat=%0d want %h lat=4", i, got_w32, lat_w32, m32);
      end
      $display("sweep%0d: A=%h B=%h Op=%b Cin=%b -> w32 S=%h lat c1/c16/w32=%0d/%0d/%0d", i,
               sw_a, sw_b, sw_op, sw_cin, got_w32[34:3], lat_c1, lat_c16, lat_w32);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
